// File: rtl/serial_pow2_divider_pkg.sv
// Shared types for the serial power-of-two signed divider.
//   state_e      : controller states (IDLE, SHIFT, DONE)
//   round_mode_e : FLOOR (plain arithmetic shift) or TRUNC (round toward zero)
package serial_pow2_divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        FLOOR = 1'b0,
        TRUNC = 1'b1
    } round_mode_e;

endpackage

// File: rtl/arith_shift_step.sv
// One-bit arithmetic right shift of a two's complement word.
// Ports:
//   w       : input word
//   shr     : w >>> 1 (sign bit replicated)
//   out_bit : the bit shifted out (w[0])
module arith_shift_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] w,
    output logic [N-1:0] shr,
    output logic         out_bit
);

    assign shr     = {w[N-1], w[N-1:1]};
    assign out_bit = w[0];

endmodule

// File: rtl/serial_pow2_signed_divider.sv
// Multi-cycle signed divide by 2^s using one arithmetic shift per clock.
// Floor mode returns the plain shift result; truncate mode adds one to a
// negative inexact result so the quotient rounds toward zero.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, s, mode)
//   a                    : dividend, two's complement
//   s                    : shift amount (any value, including s >= N)
//   mode                 : 0 = floor, 1 = truncate toward zero
//   out_valid / out_ready: result handshake
//   res                  : quotient, two's complement
//   inexact              : a 1 bit was shifted out (nonzero remainder)
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one arithmetic shift per cycle, counter counts down to 1
// DONE  | result presented, held until out_ready
module serial_pow2_signed_divider
    import serial_pow2_divider_pkg::*;
#(
    parameter int N   = 8,
    parameter int S_W = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [S_W-1:0] s,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   res,
    output logic           inexact
);

    localparam logic [S_W-1:0] CNT_ONE = {{(S_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   W_ONE   = {{(N-1){1'b0}}, 1'b1};

    state_e         state;
    round_mode_e    mode_r;
    logic [N-1:0]   w;
    logic [S_W-1:0] cnt;
    logic           sticky;

    logic [N-1:0]   w_shr;
    logic           w_out_bit;
    logic           sticky_nxt;
    logic [N-1:0]   w_inc;
    logic           round_up;

    arith_shift_step #(.N(N)) u_step (
        .w       (w),
        .shr     (w_shr),
        .out_bit (w_out_bit)
    );

    assign sticky_nxt = sticky | w_out_bit;
    assign w_inc      = w_shr + W_ONE;
    // Only negative values are bumped, so the increment can never overflow.
    assign round_up   = (mode_r == TRUNC) && w_shr[N-1] && sticky_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_r    <= FLOOR;
            w         <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            inexact   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        w        <= a;
                        cnt      <= s;
                        mode_r   <= round_mode_e'(mode);
                        sticky   <= 1'b0;
                        in_ready <= 1'b0;
                        if (s == '0) begin
                            // Nothing to shift: result is the operand itself.
                            // out_valid is raised one cycle later in DONE so
                            // latency is never below one cycle.
                            state   <= DONE;
                            res     <= a;
                            inexact <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    w      <= w_shr;
                    sticky <= sticky_nxt;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res       <= round_up ? w_inc : w_shr;
                        inexact   <= sticky_nxt;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pow2_signed_divider.sv
module tb_serial_pow2_signed_divider;

    localparam int N   = 8;
    localparam int S_W = $clog2(N) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [S_W-1:0] s;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   res;
    logic           inexact;

    int errors = 0;
    int checks = 0;

    serial_pow2_signed_divider #(.N(N), .S_W(S_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .s         (s),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the signed dividend.
    task automatic model(input logic [N-1:0] ai, input int si, input logic mi,
                         output logic [N-1:0] er, output logic ei);
        int av;
        int fl;
        int tr;
        int q;
        longint dv;
        av = int'($signed(ai));
        dv = longint'(1) << si;
        fl = int'(longint'(av) >>> si);
        tr = int'(longint'(av) / dv);
        ei = ((longint'(av) % dv) != 0);
        q  = mi ? tr : fl;
        er = q[N-1:0];
    endtask

    // Called at a negedge with the DUT idle. Runs one full transaction,
    // holding out_ready low for 'hold' cycles in DONE while toggling inputs.
    task automatic run_op(input logic [N-1:0] ai, input int si, input logic mi,
                          input int hold, input string tag);
        logic [N-1:0] er;
        logic         ei;
        int           lat;
        int           exp_lat;
        model(ai, si, mi, er, ei);
        exp_lat = (si == 0) ? 1 : si;
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ai;
        s         = S_W'(si);
        mode      = mi;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom();
        s        = S_W'($urandom());
        lat = 0;
        while (!out_valid && lat < 40) begin
            check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " res"}, 32'(res), 32'(er));
        check({tag, " inexact"}, 32'(inexact), 32'(ei));
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = $urandom_range(0, 1);
            a        = $urandom();
            s        = S_W'($urandom());
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_res"}, 32'(res), 32'(er));
            check({tag, " hold_inexact"}, 32'(inexact), 32'(ei));
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        s         = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset res", 32'(res), 32'd0);
        check("reset inexact", 32'(inexact), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'hF9, 1, 1'b0, 0, "neg7_s1_floor");
        run_op(8'hF9, 1, 1'b1, 0, "neg7_s1_trunc");
        run_op(8'h40, 3, 1'b0, 0, "p64_s3_floor");
        run_op(8'h40, 3, 1'b1, 0, "p64_s3_trunc");
        run_op(8'hF8, 3, 1'b1, 0, "neg8_s3_trunc");
        run_op(8'h80, 7, 1'b0, 0, "min_s7_floor");
        run_op(8'h80, 7, 1'b1, 0, "min_s7_trunc");
        run_op(8'hFF, 9, 1'b0, 0, "neg1_s9_floor");
        run_op(8'hFF, 9, 1'b1, 0, "neg1_s9_trunc");
        run_op(8'h5A, 0, 1'b1, 0, "s0_pass");
        run_op(8'h40, 3, 1'b0, 5, "backpressure");

        // Reset in the middle of a long shift must abort silently.
        in_valid = 1'b1;
        a        = 8'h80;
        s        = S_W'(6);
        mode     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst res", 32'(res), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst no_output", 32'(out_valid), 32'd0);
        end
        run_op(8'h80, 6, 1'b1, 0, "after_rst");

        for (int k = 0; k < 30; k++) begin
            run_op(N'($urandom()), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
